// File: rtl/csa_sub_seq_if.sv
// Start/done bus for the sequential carry-select subtractor.
// Handshake: start is sampled only while idle; busy covers RUN and DONE; done is a one-cycle pulse.
interface csa_sub_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/csa_sub_seq.sv
// Multi-cycle carry-select subtractor: diff = a - b - bin, one SLICE-bit slice per clock, LSB first.
// Optional signed-overflow flag built only when CSA_SUB_OVF_EN is defined.
module csa_sub_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic         clk,
  input  logic         rst,
  csa_sub_seq_if.slave s,
  output logic [1:0]   state_dbg
);
  localparam int NS = WIDTH / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             brw;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             busy_q;
  logic             done_q;
  logic             bout_q;

  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE:0]   d0;
  logic [SLICE:0]   d1;
  logic [SLICE:0]   sel;

  // Both borrow-in candidates are formed every cycle; the running borrow only picks one.
  // A carry-out of 1 from a + ~b (+1) means no borrow leaves the slice.
  always_comb begin
    a_s = a_q[idx*SLICE +: SLICE];
    b_s = b_q[idx*SLICE +: SLICE];
    d0  = {1'b0, a_s} + {1'b0, ~b_s} + (SLICE+1)'(1);
    d1  = {1'b0, a_s} + {1'b0, ~b_s};
    sel = brw ? d1 : d0;
  end

`ifdef CSA_SUB_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && idx == IW'(NS-1)) begin
      ovf_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ sel[SLICE-1]);
    end
  end
  assign s.ovf = ovf_q;
`else
  assign s.ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      brw    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s.start) begin
            a_q    <= s.a;
            b_q    <= s.b;
            brw    <= s.bin;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          diff_q[idx*SLICE +: SLICE] <= sel[SLICE-1:0];
          brw <= ~sel[SLICE];
          idx <= idx + IW'(1);
          if (idx == IW'(NS-1)) begin
            bout_q <= ~sel[SLICE];
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s.busy    = busy_q;
  assign s.done    = done_q;
  assign s.diff    = diff_q;
  assign s.bout    = bout_q;
  assign state_dbg = state;
endmodule

// File: tb/tb_csa_sub_seq.sv
// Bench for csa_sub_seq: directed and random subtractions against an arithmetic model,
// plus start-while-busy and mid-run reset scenarios.
module tb_csa_sub_seq;
  localparam int W  = 16;
  localparam int SL = 4;
  localparam int NS = W / SL;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         fails  = 0;
  logic [W+1:0] exp_q[$];

  csa_sub_seq_if #(.WIDTH(W)) ifc ();

  csa_sub_seq #(.WIDTH(W), .SLICE(SL)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (ifc),
    .state_dbg (state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // reference model: returns {ovf, bout, diff}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    int         ia, ib;
    logic [W-1:0] d;
    logic       bo, ov;
    ia = int'(a);
    ib = int'(b);
    d  = W'(ia - ib - int'(bin));
    bo = (ia < ib + int'(bin));
`ifdef CSA_SUB_OVF_EN
    ov = (a[W-1] ^ b[W-1]) & (a[W-1] ^ d[W-1]);
`else
    ov = 1'b0;
`endif
    return {ov, bo, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: issue one operation; with poke, hold start high (a=FFFF, b=0) through RUN and DONE
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit poke);
    logic [W+1:0] e;
    int lat;
    exp_q.push_back(model(a, b, bin));
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.a     = a;
    ifc.b     = b;
    ifc.bin   = bin;
    @(posedge clk);
    #1;
    if (poke) begin
      ifc.a   = '1;
      ifc.b   = '0;
      ifc.bin = 1'b0;
    end else begin
      ifc.start = 1'b0;
      ifc.a     = W'($urandom);
      ifc.b     = W'($urandom);
      ifc.bin   = 1'($urandom);
    end
    lat = 0;
    for (int i = 1; i <= NS + 4; i++) begin
      @(negedge clk);
      if (ifc.done) begin
        lat = i;
        break;
      end
      check("busy_run", 32'(ifc.busy), 32'd1);
    end
    e = exp_q.pop_front();
    check("latency", 32'(lat), 32'(NS + 1));
    if (lat != 0) begin
      check("diff", 32'(ifc.diff), 32'(e[W-1:0]));
      check("bout", 32'(ifc.bout), 32'(e[W]));
      check("ovf",  32'(ifc.ovf),  32'(e[W+1]));
      check("busy_done", 32'(ifc.busy), 32'd1);
    end
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    @(negedge clk);
    check("done_pulse_end", 32'(ifc.done), 32'd0);
    check("busy_idle", 32'(ifc.busy), 32'd0);
  endtask

  initial begin
    int dn;
    logic [W-1:0] r;
    rst       = 1'b1;
    ifc.start = 1'b0;
    ifc.a     = '0;
    ifc.b     = '0;
    ifc.bin   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_diff", 32'(ifc.diff), 32'd0);
    check("rst_bout", 32'(ifc.bout), 32'd0);
    check("rst_ovf",  32'(ifc.ovf),  32'd0);
    rst = 1'b0;

    // directed cases
    run_op(16'h1234, 16'h0234, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0003, 1'b1, 1'b0);
    run_op(16'h00FF, 16'h00FF, 1'b1, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b0);
    run_op(16'h1234, 16'h0234, 1'b0, 1'b1);
    run_op(16'h0F0F, 16'h0F10, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);

    // reset during the second RUN cycle
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.a     = 16'h1234;
    ifc.b     = 16'h0234;
    ifc.bin   = 1'b0;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(ifc.busy), 32'd0);
    check("abort_done", 32'(ifc.done), 32'd0);
    check("abort_diff", 32'(ifc.diff), 32'd0);
    check("abort_bout", 32'(ifc.bout), 32'd0);
    check("abort_ovf",  32'(ifc.ovf),  32'd0);
    rst = 1'b0;
    dn  = 0;
    repeat (8) begin
      @(negedge clk);
      if (ifc.done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    run_op(16'h1234, 16'h0234, 1'b0, 1'b0);

    // random operations, some with start held during RUN/DONE
    for (int n = 0; n < 40; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    // equal operands with borrow-in
    for (int n = 0; n < 4; n++) begin
      r = W'($urandom);
      run_op(r, r, 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
